fifo_pop_arbiter: RTL and testbench

Round-robin read-side arbiter that drains four input FIFOs (the 8x10-bit `FIFO_cond` instances) and routes each popped word to one of four output FIFOs by destination field. It drives each input FIFO's `rd_enb` from its `empty` flag and stalls on any output FIFO's `alm_full`. It sits between the ingress FIFO bank and the egress FIFO bank, one instance per link.

---
 rtl/fifo_pop_arbiter_pkg.sv | 28 ++
 rtl/fifo_pop_arbiter_rr_grant4.sv | 35 +++
 rtl/fifo_pop_arbiter.sv | 152 +++++++++++++++
 tb/tb_fifo_pop_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pop_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pop_arbiter_pkg
// Description : Shared constants, state encoding and helpers for the
//               four-port FIFO pop arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pop_arbiter_pkg;

    localparam int N_PORTS  = 4;
    localparam int DATA_W   = 10;
    localparam int CNT_W    = 5;
    localparam int IDX_W    = 2;
    localparam int DEST_MSB = DATA_W - 1;
    localparam int DEST_LSB = DATA_W - 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_PAUSE  = 2'd2
    } state_t;

    function automatic logic [IDX_W-1:0] dest_of(input logic [DATA_W-1:0] word);
        return word[DEST_MSB:DEST_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_pop_arbiter_rr_grant4.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant4
// Description : Combinational 4-way round-robin picker; the search starts at
//               the port after the last one granted.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant4
    import fifo_pop_arbiter_pkg::*;
(
    input  logic [N_PORTS-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [N_PORTS-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    always_comb begin
        logic [IDX_W-1:0] w_idx;
        w_idx   = last;
        gnt_idx = last;
        // Walk from farthest to nearest so the nearest requester wins.
        for (int k = N_PORTS; k >= 1; k--) begin
            w_idx = last + IDX_W'(k);
            if (req[w_idx]) begin
                gnt_idx = w_idx;
            end
        end
        gnt = '0;
        if (|req) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_pop_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pop_arbiter
// Description : Round-robin drain of four ingress FIFOs into four egress
//               FIFOs selected by the word's destination field.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_pop_arbiter
    import fifo_pop_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [N_PORTS-1:0]  in_empty,
    input  logic [DATA_W-1:0]   in_data0,
    input  logic [DATA_W-1:0]   in_data1,
    input  logic [DATA_W-1:0]   in_data2,
    input  logic [DATA_W-1:0]   in_data3,
    input  logic [N_PORTS-1:0]  out_alm_full,
    output logic [N_PORTS-1:0]  pop,
    output logic [N_PORTS-1:0]  push,
    output logic [DATA_W-1:0]   out_data,
    output logic                idle,
    output logic [CNT_W-1:0]    cnt0,
    output logic [CNT_W-1:0]    cnt1,
    output logic [CNT_W-1:0]    cnt2,
    output logic [CNT_W-1:0]    cnt3
);

    state_t             state_q, state_d;
    logic               vld_q, vld_d;
    logic [IDX_W-1:0]   src_q, src_d;
    logic [IDX_W-1:0]   last_q, last_d;

    logic               w_stall;
    logic               w_any_req;
    logic               w_pop_en;
    logic [N_PORTS-1:0] w_gnt;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic [N_PORTS-1:0] w_pop;
    logic [DATA_W-1:0]  w_word;
    logic [CNT_W-1:0]   w_cnt [N_PORTS];

    assign w_stall   = |out_alm_full;
    assign w_any_req = ~&in_empty;

    rr_grant4 u_rr_grant4 (
        .req     (~in_empty),
        .last    (last_q),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            vld_q   <= 1'b0;
            src_q   <= '0;
            last_q  <= IDX_W'(N_PORTS - 1);
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            src_q   <= src_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (w_any_req) begin
                    state_d = w_stall ? ST_PAUSE : ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (w_stall) begin
                    state_d = ST_PAUSE;
                end else if (!w_any_req) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PAUSE: begin
                if (!w_stall) begin
                    state_d = w_any_req ? ST_ACTIVE : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Popping in the entry cycle lets a word leave the FIFO the same
        // cycle the request or stall release is seen; reset suppresses it.
        w_pop_en = ~rst & ~w_stall &
                   ((state_q == ST_ACTIVE) | (state_d == ST_ACTIVE));
        w_pop    = w_pop_en ? w_gnt : '0;
        idle     = (state_q == ST_IDLE);
    end

    assign pop = w_pop;

    always_comb begin
        vld_d  = |w_pop;
        src_d  = src_q;
        last_d = last_q;
        if (|w_pop) begin
            src_d  = w_gnt_idx;
            last_d = w_gnt_idx;
        end
    end

    // The FIFO output register presents the popped word one cycle after pop.
    always_comb begin
        unique case (src_q)
            2'd0:    w_word = in_data0;
            2'd1:    w_word = in_data1;
            2'd2:    w_word = in_data2;
            default: w_word = in_data3;
        endcase
        push     = '0;
        out_data = '0;
        if (vld_q) begin
            push[dest_of(w_word)] = 1'b1;
            out_data              = w_word;
        end
    end

    generate
        for (genvar j = 0; j < N_PORTS; j++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q + CNT_W'(push[j]);
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign w_cnt[j] = cnt_q;
        end
    endgenerate

    assign cnt0 = w_cnt[0];
    assign cnt1 = w_cnt[1];
    assign cnt2 = w_cnt[2];
    assign cnt3 = w_cnt[3];

endmodule
`default_nettype wire

// File: tb/tb_fifo_pop_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_pop_arbiter
// Description : Directed self-checking bench with behavioural ingress FIFOs
//               and an occupancy model of egress FIFO 3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_pop_arbiter;
    import fifo_pop_arbiter_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        in_empty;
    logic [9:0]        in_data [4];
    logic [3:0]        out_alm_full;
    logic [3:0]        pop;
    logic [3:0]        push;
    logic [9:0]        out_data;
    logic              idle;
    logic [4:0]        cnt0, cnt1, cnt2, cnt3;

    fifo_pop_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .in_empty     (in_empty),
        .in_data0     (in_data[0]),
        .in_data1     (in_data[1]),
        .in_data2     (in_data[2]),
        .in_data3     (in_data[3]),
        .out_alm_full (out_alm_full),
        .pop          (pop),
        .push         (push),
        .out_data     (out_data),
        .idle         (idle),
        .cnt0         (cnt0),
        .cnt1         (cnt1),
        .cnt2         (cnt2),
        .cnt3         (cnt3)
    );

    always #10 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [9:0] qd [4][48];
    int         wr [4];
    int         rd [4];
    int         occ3, occ3_peak, ovf_viol, push0_seen;
    bit         ovf_mode;

    typedef struct {
        int         src;
        logic [9:0] word;
        logic [3:0] exp_pop;
        logic [3:0] exp_push;
    } vec_t;

    vec_t vecs [5];
    int   ecnt [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] cnt_of(input int j);
        case (j)
            0:       return cnt0;
            1:       return cnt1;
            2:       return cnt2;
            default: return cnt3;
        endcase
    endfunction

    task automatic upd_empty();
        for (int i = 0; i < 4; i++) in_empty[i] = (rd[i] == wr[i]);
    endtask

    task automatic load(input int i, input logic [9:0] w);
        qd[i][wr[i]] = w;
        wr[i]++;
        upd_empty();
    endtask

    task automatic clear_fifos();
        for (int i = 0; i < 4; i++) begin
            wr[i] = 0;
            rd[i] = 0;
            in_data[i] = '0;
        end
        upd_empty();
    endtask

    // One clock: sample pre-edge pop/push, then update the FIFO models.
    task automatic tick();
        logic [3:0] p, ps;
        #1;
        p  = pop;
        ps = push;
        if (ovf_mode && ps[3] && occ3 >= 7) ovf_viol++;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (p[i]) begin
                in_data[i] = qd[i][rd[i]];
                rd[i]++;
            end
        end
        upd_empty();
        if (ps[3]) occ3++;
        if (ps[0]) push0_seen++;
        if (occ3 > occ3_peak) occ3_peak = occ3;
        if (ovf_mode) out_alm_full[3] = (occ3 >= 6);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        #1;
        clear_fifos();
        occ3 = 0; occ3_peak = 0; ovf_viol = 0; push0_seen = 0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [9:0] w, prev_w;
        rst = 1'b1;
        out_alm_full = '0;
        ovf_mode = 1'b0;
        occ3 = 0; occ3_peak = 0; ovf_viol = 0; push0_seen = 0;
        clear_fifos();

        vecs[0] = '{2, 10'h1A5, 4'b0100, 4'b0010};
        vecs[1] = '{0, 10'h0C3, 4'b0001, 4'b0001};
        vecs[2] = '{3, 10'h2F0, 4'b1000, 4'b0100};
        vecs[3] = '{1, 10'h3AA, 4'b0010, 4'b1000};
        vecs[4] = '{2, 10'h355, 4'b0100, 4'b1000};
        for (int j = 0; j < 4; j++) ecnt[j] = 0;

        @(posedge clk);
        #2;
        chk("reset_pop", 32'(pop), 0);
        chk("reset_push", 32'(push), 0);
        chk("reset_out_data", 32'(out_data), 0);
        chk("reset_idle", 32'(idle), 1);
        for (int j = 0; j < 4; j++) chk($sformatf("reset_cnt%0d", j), 32'(cnt_of(j)), 0);
        rst = 1'b0;
        #1;

        // Single-word vectors
        for (int v = 0; v < 5; v++) begin
            load(vecs[v].src, vecs[v].word);
            #1;
            chk($sformatf("vec%0d_pop", v), 32'(pop), 32'(vecs[v].exp_pop));
            tick();
            chk($sformatf("vec%0d_push", v), 32'(push), 32'(vecs[v].exp_push));
            chk($sformatf("vec%0d_data", v), 32'(out_data), 32'(vecs[v].word));
            ecnt[vecs[v].word[9:8]]++;
            tick();
            chk($sformatf("vec%0d_cnt", v), 32'(cnt_of(int'(vecs[v].word[9:8]))),
                32'(ecnt[vecs[v].word[9:8]]));
            chk($sformatf("vec%0d_idle", v), 32'(idle), 1);
            chk($sformatf("vec%0d_push_after", v), 32'(push), 0);
        end

        // Reset mid-stream with a word in flight
        load(1, 10'h0AB);
        load(1, 10'h0AC);
        load(3, 10'h1CD);
        #1;
        chk("mid_pop", 32'(pop), 32'h8);
        tick();
        chk("mid_push_before_rst", 32'(push), 32'h2);
        rst = 1'b1;
        #1;
        chk("mid_rst_push", 32'(push), 0);
        chk("mid_rst_out_data", 32'(out_data), 0);
        chk("mid_rst_idle", 32'(idle), 1);
        chk("mid_rst_pop", 32'(pop), 0);
        for (int j = 0; j < 4; j++) chk($sformatf("mid_rst_cnt%0d", j), 32'(cnt_of(j)), 0);
        clear_fifos();
        tick();
        rst = 1'b0;
        #1;

        // Fairness: three words in each input
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 4; i++)
                load(i, {k[1:0], i[3:0], k[3:0]});
        #1;
        prev_w = '0;
        for (int c = 0; c < 12; c++) begin
            w = {2'(c / 4), 4'(c % 4), 4'(c / 4)};
            chk($sformatf("fair_pop%0d", c), 32'(pop), 32'(4'b0001 << (c % 4)));
            if (c > 0) chk($sformatf("fair_data%0d", c), 32'(out_data), 32'(prev_w));
            prev_w = w;
            tick();
        end
        chk("fair_last_data", 32'(out_data), 32'(prev_w));
        chk("fair_idle12", 32'(idle), 0);
        tick();
        chk("fair_idle13", 32'(idle), 1);
        chk("fair_push13", 32'(push), 0);
        chk("fair_cnt0", 32'(cnt0), 4);
        chk("fair_cnt1", 32'(cnt1), 4);
        chk("fair_cnt2", 32'(cnt2), 4);
        chk("fair_cnt3", 32'(cnt3), 0);

        // Stall and resume
        load(0, 10'h311);
        load(0, 10'h012);
        load(1, 10'h123);
        load(1, 10'h224);
        #1;
        chk("stall_A_pop", 32'(pop), 32'h1);
        tick();
        out_alm_full = 4'b1000;
        #1;
        chk("stall_B_pop", 32'(pop), 0);
        chk("stall_B_push", 32'(push), 32'h8);
        chk("stall_B_data", 32'(out_data), 32'h311);
        tick();
        chk("stall_C_pop", 32'(pop), 0);
        chk("stall_C_push", 32'(push), 0);
        chk("stall_C_idle", 32'(idle), 0);
        tick();
        out_alm_full = 4'b0000;
        #1;
        chk("stall_D_pop", 32'(pop), 32'h2);
        chk("stall_D_push", 32'(push), 0);
        tick();
        chk("stall_E_pop", 32'(pop), 32'h1);
        chk("stall_E_push", 32'(push), 32'h2);
        chk("stall_E_data", 32'(out_data), 32'h123);
        tick();
        chk("stall_F_pop", 32'(pop), 32'h2);
        chk("stall_F_push", 32'(push), 32'h1);
        chk("stall_F_data", 32'(out_data), 32'h012);
        tick();
        chk("stall_G_pop", 32'(pop), 0);
        chk("stall_G_push", 32'(push), 32'h4);
        chk("stall_G_data", 32'(out_data), 32'h224);
        tick();
        chk("stall_H_idle", 32'(idle), 1);

        // Overflow safety: everything to dest 3, never drained
        reset_pulse();
        ovf_mode = 1'b1;
        for (int n = 0; n < 12; n++) load(n % 4, {2'b11, 8'(n)});
        #1;
        repeat (30) tick();
        chk("ovf_peak", 32'(occ3_peak), 7);
        chk("ovf_push_at_7", 32'(ovf_viol), 0);
        chk("ovf_cnt3", 32'(cnt3), 7);
        chk("ovf_pop_stalled", 32'(pop), 0);
        ovf_mode = 1'b0;
        out_alm_full = '0;

        // Counter wrap: 33 words to dest 0
        reset_pulse();
        for (int n = 0; n < 33; n++) load(n % 4, {2'b00, 8'(n)});
        #1;
        repeat (37) tick();
        chk("wrap_pushes", 32'(push0_seen), 33);
        chk("wrap_cnt0", 32'(cnt0), 1);
        chk("wrap_cnt1", 32'(cnt1), 0);
        chk("wrap_cnt3", 32'(cnt3), 0);
        chk("wrap_drained", 32'(in_empty), 32'hF);
        chk("wrap_idle", 32'(idle), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
